tap_delay_bank: RTL
===================

TAP_DELAY_BANK -- requirements
Module: tap_delay_bank

Interface
REQ-001 SHALL have parameter N_TAPS, default 8, meaning taps per channel (>=2).
REQ-002 SHALL have parameter SIZE, default 8, meaning sample width in bits.
REQ-003 SHALL have parameter CHANNELS, default 2, meaning independent delay lines (>=1); CW = max(1, clog2(CHANNELS)).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  sample offered.
REQ-007 SHALL have port in_ready  output  1  sample accepted when in_valid && in_ready at a rising edge.
REQ-008 SHALL have port in_chan  input  CW  target channel of offered sample.
REQ-009 SHALL have port in_data  input  SIZE  offered sample.
REQ-010 SHALL have port flush  input  1  clear request for channel flush_chan.
REQ-011 SHALL have port flush_chan  input  CW  channel to clear.
REQ-012 SHALL have port out_valid  output  1  tap snapshot held for consumer.
REQ-013 SHALL have port out_ready  input  1  consumer takes snapshot when out_valid && out_ready.
REQ-014 SHALL have port out_taps  output  N_TAPS*SIZE  snapshot; bits [SIZE-1:0] newest sample, top SIZE bits oldest.
REQ-015 SHALL have port out_chan  output  CW  channel of snapshot.
REQ-016 SHALL have port out_primed  output  1  snapshot channel had received >= N_TAPS samples since last reset/flush.

Function
REQ-017 SHALL keep per channel an N_TAPS x SIZE delay line and a fill counter saturating at N_TAPS.
REQ-018 SHALL drive in_ready = !flush && (!out_valid || out_ready), combinationally.
REQ-019 SHALL, on accept, shift channel in_chan: new line = {old line[(N_TAPS-1)*SIZE-1:0], in_data}; other channels unchanged.
REQ-020 SHALL, on accept, increment that channel's fill counter unless already N_TAPS.
REQ-021 SHALL, on the same edge as accept, load out_taps with the post-shift line, out_chan = in_chan, out_primed = (post-increment count == N_TAPS), and set out_valid = 1 (latency one edge).
REQ-022 SHALL clear out_valid on an edge where out_valid && out_ready and no accept occurs; out_taps/out_chan/out_primed hold their values.
REQ-023 SHALL hold out_valid, out_taps, out_chan, out_primed stable while out_valid && !out_ready (no overwrite, no drop).
REQ-024 SHALL, on an edge with flush=1, zero delay line and fill counter of flush_chan only; no accept occurs that cycle (in_ready=0).
REQ-025 SHALL leave a pending snapshot (out_valid=1) unchanged by a flush, even for the same channel.
REQ-026 SHALL ignore in_chan/flush_chan values >= CHANNELS: no state change for that action, accept handshake still completes.
REQ-027 SHALL never present X on outputs after reset deassertion.

Reset
REQ-028 SHALL, while reset=1 (asynchronously, no clock needed), force all delay lines and fill counters to 0, out_valid=0, out_taps=0, out_chan=0, out_primed=0.
REQ-029 SHALL abandon any in-flight snapshot on reset; first accept after reset deassertion behaves as a fresh channel.

Verification
REQ-030 N_TAPS=4,SIZE=8,CHANNELS=2, out_ready=1: accept 0x11,0x22,0x33,0x44 on ch0 -> 4th snapshot out_taps=0x11223344, out_primed=1; first three out_primed=0.
REQ-031 Interleave ch0 0xA1, ch1 0xB1, ch0 0xA2 -> snapshots 0x000000A1 (ch0), 0x000000B1 (ch1), 0x0000A1A2 (ch0); channels isolated.
REQ-032 Backpressure: out_ready=0 after one accept -> in_ready=0, out_taps held over 5 cycles; raise out_ready with in_valid=1 -> next sample accepted same edge, no loss.
REQ-033 Fill ch1 with 4 samples, flush ch1, accept 0x55 on ch1 -> out_taps=0x00000055, out_primed=0; ch0 contents unchanged.
REQ-034 Flush and in_valid same cycle -> in_ready=0, no accept; sample accepted next cycle.
REQ-035 Assert reset mid-stream between edges -> outputs zero immediately, before next clk edge; restart yields 0x000000xx snapshot.

Source files
------------

// File: rtl/tap_delay_bank_if.sv
// Sample-in / snapshot-out bus for the tap delay bank.
// The master side offers samples, flush requests and consumer readiness;
// the slave side (the bank) answers with acceptance and tap snapshots.
interface tap_delay_bank_if #(
    parameter int N_TAPS   = 8,
    parameter int SIZE     = 8,
    parameter int CHANNELS = 2
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                   in_valid;
    logic                   in_ready;
    logic [CW-1:0]          in_chan;
    logic [SIZE-1:0]        in_data;
    logic                   flush;
    logic [CW-1:0]          flush_chan;
    logic                   out_valid;
    logic                   out_ready;
    logic [N_TAPS*SIZE-1:0] out_taps;
    logic [CW-1:0]          out_chan;
    logic                   out_primed;

    modport master (
        output in_valid, in_chan, in_data, flush, flush_chan, out_ready,
        input  in_ready, out_valid, out_taps, out_chan, out_primed
    );

    modport slave (
        input  in_valid, in_chan, in_data, flush, flush_chan, out_ready,
        output in_ready, out_valid, out_taps, out_chan, out_primed
    );
endinterface

// File: rtl/tap_delay_bank.sv
// Bank of independent per-channel tapped delay lines.
// Each accepted sample shifts into its channel's line and the resulting
// full tap vector is presented as a held snapshot for a downstream consumer.
// Channel numbers at or beyond CHANNELS are accepted but change nothing.
module tap_delay_bank #(
    parameter int N_TAPS   = 8,
    parameter int SIZE     = 8,
    parameter int CHANNELS = 2
) (
    input logic            clk,
    input logic            reset,
    tap_delay_bank_if.slave bus
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int FW = $clog2(N_TAPS + 1);
    localparam int LW = N_TAPS * SIZE;
    localparam logic [FW-1:0] FULL = FW'(N_TAPS);

    logic [LW-1:0] r_lines [CHANNELS];
    logic [FW-1:0] r_fill  [CHANNELS];

    logic          r_outValid;
    logic [LW-1:0] r_outTaps;
    logic [CW-1:0] r_outChan;
    logic          r_outPrimed;

    logic          w_inReady;
    logic          w_accept;
    logic          w_inChanOk;
    logic [LW-1:0] w_curLine;
    logic [FW-1:0] w_curFill;
    logic [LW-1:0] w_shifted;
    logic [FW-1:0] w_fillNext;

    // A new sample may enter only when no flush is pending and the held
    // snapshot is either empty or being taken this cycle.
    assign w_inReady = !bus.flush && (!r_outValid || bus.out_ready);
    assign w_accept  = bus.in_valid && w_inReady;

    // Fetch the addressed channel's line and fill count; an unknown channel
    // leaves w_inChanOk low so the accept becomes a no-op.
    always_comb begin
        w_curLine  = '0;
        w_curFill  = '0;
        w_inChanOk = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.in_chan == CW'(c)) begin
                w_curLine  = r_lines[c];
                w_curFill  = r_fill[c];
                w_inChanOk = 1'b1;
            end
        end
    end

    assign w_shifted  = {w_curLine[(N_TAPS-1)*SIZE-1:0], bus.in_data};
    assign w_fillNext = (w_curFill == FULL) ? w_curFill : w_curFill + FW'(1);

    // Per-channel delay lines: flush clears one channel, accept shifts one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_lines[c] <= '0;
                r_fill[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (bus.flush && (bus.flush_chan == CW'(c))) begin
                    r_lines[c] <= '0;
                    r_fill[c]  <= '0;
                end else if (w_accept && (bus.in_chan == CW'(c))) begin
                    r_lines[c] <= w_shifted;
                    r_fill[c]  <= w_fillNext;
                end
            end
        end
    end

    // Snapshot register: loads on a real accept, empties when consumed,
    // otherwise holds so a stalled consumer never loses or sees a change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid  <= 1'b0;
            r_outTaps   <= '0;
            r_outChan   <= '0;
            r_outPrimed <= 1'b0;
        end else if (w_accept && w_inChanOk) begin
            r_outValid  <= 1'b1;
            r_outTaps   <= w_shifted;
            r_outChan   <= bus.in_chan;
            r_outPrimed <= (w_fillNext == FULL);
        end else if (r_outValid && bus.out_ready) begin
            r_outValid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_inReady;
    assign bus.out_valid  = r_outValid;
    assign bus.out_taps   = r_outTaps;
    assign bus.out_chan   = r_outChan;
    assign bus.out_primed = r_outPrimed;
endmodule
